// File: rtl/prefetch_unit.sv
// Instruction prefetcher: issues sequential pipelined Wishbone reads and delivers the
// responses in order to a valid/ready consumer, with redirect (flush) and fault halt.
module prefetch_unit #(
   parameter logic [31:0] RESET_PC        = 32'h8000_0000,
   parameter int          FIFO_DEPTH      = 8,
   parameter int          MAX_OUTSTANDING = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_flush,
   input  logic [31:0] pc_new,
   output logic        bus_cyc,
   output logic        bus_stb,
   output logic [31:0] bus_adr,
   output logic        bus_we,
   output logic [3:0]  bus_sel,
   output logic [31:0] bus_dat_w,
   input  logic        bus_stall,
   input  logic        bus_ack,
   input  logic        bus_err,
   input  logic [31:0] bus_dat_r,
   output logic        dn_valid,
   input  logic        dn_ready,
   output logic [31:0] dn_instr,
   output logic [31:0] dn_pc,
   output logic        dn_fault
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        fault;
   } entry_t;

   entry_t           mem [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] out_next;
   logic [CNT_W-1:0] discard;
   logic [CNT_W-1:0] discard_next;
   logic [CNT_W:0]   budget;
   logic [31:0]      fetch_pc;
   logic [31:0]      resp_pc;
   logic             halt;
   logic             halt_next;
   logic             stb_next;
   logic             accept;
   logic             resp;
   logic             keep;
   logic             q_empty;
   logic             push;
   logic             pop;
   entry_t           new_entry;
   entry_t           head;

   assign bus_we    = 1'b0;
   assign bus_sel   = 4'hF;
   assign bus_dat_w = 32'h0;
   assign bus_adr   = fetch_pc;
   assign bus_cyc   = bus_stb | (outstanding != '0);

   // A response is kept only when no pre-flush responses remain to be dropped;
   // anything arriving in the flush cycle itself belongs to the old stream.
   assign accept  = bus_stb & ~bus_stall;
   assign resp    = bus_ack | bus_err;
   assign keep    = resp & (discard == '0) & ~pc_flush;
   assign q_empty = (count == '0);
   assign head    = mem[rd_ptr];

   assign new_entry.instr = bus_err ? 32'h0 : bus_dat_r;
   assign new_entry.pc    = resp_pc;
   assign new_entry.fault = bus_err;

   assign dn_valid = ~pc_flush & (q_empty ? keep : 1'b1);
   assign dn_instr = q_empty ? new_entry.instr : head.instr;
   assign dn_pc    = q_empty ? new_entry.pc    : head.pc;
   assign dn_fault = q_empty ? new_entry.fault : head.fault;

   assign push = keep & (~q_empty | ~dn_ready);
   assign pop  = ~q_empty & dn_ready & ~pc_flush;

   always_comb begin
      out_next     = outstanding;
      discard_next = discard;
      count_next   = count;
      halt_next    = halt;
      if (accept && !resp) begin
         out_next = outstanding + ONE;
      end else if (!accept && resp) begin
         out_next = outstanding - ONE;
      end
      if (push && !pop) begin
         count_next = count + ONE;
      end else if (!push && pop) begin
         count_next = count - ONE;
      end
      if (keep && bus_err) begin
         halt_next = 1'b1;
      end
      if (resp && discard != '0) begin
         discard_next = discard - ONE;
      end
      if (pc_flush) begin
         discard_next = out_next;
         count_next   = '0;
         halt_next    = 1'b0;
      end
   end

   // Issue only while every response that could still arrive has a guaranteed
   // queue slot; a request already on the bus is held until it is taken.
   always_comb begin
      budget   = {1'b0, count_next} + {1'b0, out_next};
      stb_next = (budget < (CNT_W+1)'(FIFO_DEPTH)) && (out_next < CNT_W'(MAX_OUTSTANDING)) &&
                 !halt_next && (discard_next == '0);
      if (bus_stb && bus_stall) begin
         stb_next = 1'b1;
      end
      if (pc_flush) begin
         stb_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         bus_stb     <= 1'b0;
         outstanding <= '0;
         discard     <= '0;
         halt        <= 1'b0;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else begin
         bus_stb     <= stb_next;
         outstanding <= out_next;
         discard     <= discard_next;
         halt        <= halt_next;
         count       <= count_next;
         if (pc_flush) begin
            fetch_pc <= pc_new;
            resp_pc  <= pc_new;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
         end else begin
            if (accept) begin
               fetch_pc <= fetch_pc + 32'd4;
            end
            if (keep) begin
               resp_pc <= resp_pc + 32'd4;
            end
            if (push) begin
               wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PTR_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= new_entry;
      end
   end

   a_no_overflow : assert property (@(posedge clk) disable iff (rst)
      !(push && !pop && count == CNT_W'(FIFO_DEPTH)));
   a_outstanding_limit : assert property (@(posedge clk) disable iff (rst)
      outstanding <= CNT_W'(MAX_OUTSTANDING));
   a_no_orphan_response : assert property (@(posedge clk) disable iff (rst)
      !(resp && outstanding == '0));

endmodule

// File: tb/tb_prefetch_unit.sv
// Bench for prefetch_unit: directed vectors and corner sequences on a default instance,
// randomized bus/consumer traffic against a transaction-level model on a small instance.
module tb_prefetch_unit;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        fault;
   } item_t;

   typedef struct {
      logic [31:0] addr;
      logic        stale;
      int          due;
   } pend_t;

   typedef struct {
      logic        ready;
      logic        stall;
      logic        exp_stb;
      logic [31:0] exp_adr;
      logic        exp_valid;
      logic [31:0] exp_pc;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic        a_flush, a_cyc, a_stb, a_we, a_stall, a_ack, a_err, a_valid, a_ready, a_fault;
   logic [31:0] a_pc_new, a_adr, a_dat_w, a_dat_r, a_instr, a_pc;
   logic [3:0]  a_sel;
   logic        b_flush, b_cyc, b_stb, b_we, b_stall, b_ack, b_err, b_valid, b_ready, b_fault;
   logic [31:0] b_pc_new, b_adr, b_dat_w, b_dat_r, b_instr, b_pc;
   logic [3:0]  b_sel;

   prefetch_unit dut (
      .clk(clk), .rst(rst), .pc_flush(a_flush), .pc_new(a_pc_new),
      .bus_cyc(a_cyc), .bus_stb(a_stb), .bus_adr(a_adr), .bus_we(a_we), .bus_sel(a_sel),
      .bus_dat_w(a_dat_w), .bus_stall(a_stall), .bus_ack(a_ack), .bus_err(a_err),
      .bus_dat_r(a_dat_r), .dn_valid(a_valid), .dn_ready(a_ready), .dn_instr(a_instr),
      .dn_pc(a_pc), .dn_fault(a_fault)
   );

   prefetch_unit #(.FIFO_DEPTH(4), .MAX_OUTSTANDING(2)) dut_rand (
      .clk(clk), .rst(rst), .pc_flush(b_flush), .pc_new(b_pc_new),
      .bus_cyc(b_cyc), .bus_stb(b_stb), .bus_adr(b_adr), .bus_we(b_we), .bus_sel(b_sel),
      .bus_dat_w(b_dat_w), .bus_stall(b_stall), .bus_ack(b_ack), .bus_err(b_err),
      .bus_dat_r(b_dat_r), .dn_valid(b_valid), .dn_ready(b_ready), .dn_instr(b_instr),
      .dn_pc(b_pc), .dn_fault(b_fault)
   );

   int compared   = 0;
   int mismatched = 0;

   item_t       a_log[$];
   logic [31:0] a_pend[$];
   logic [31:0] a_acc[$];
   logic [31:0] a_err_addr;

   pend_t       b_pend[$];
   item_t       b_exp[$];
   logic [31:0] model_pc;
   logic        halted, prev_stb, prev_pending, prev_flush;
   int          cyc_n;

   vec_t vecs[9];

   function automatic logic [31:0] data_of(input logic [31:0] addr);
      return (addr ^ 32'h5A5A_0000) + 32'h13;
   endfunction

   function automatic item_t log_at(input int i);
      if (i < a_log.size()) return a_log[i];
      return '0;
   endfunction

   function automatic logic [31:0] acc_at(input int i);
      if (i < a_acc.size()) return a_acc[i];
      return 32'h0;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      a_flush = 1'b0; a_pc_new = 32'h0; a_stall = 1'b0; a_ack = 1'b0; a_err = 1'b0;
      a_dat_r = 32'h0; a_ready = 1'b1;
      b_flush = 1'b0; b_pc_new = 32'h0; b_stall = 1'b0; b_ack = 1'b0; b_err = 1'b0;
      b_dat_r = 32'h0; b_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      checkOutput("reset stb", 32'(a_stb), 32'h0);
      checkOutput("reset cyc", 32'(a_cyc), 32'h0);
      checkOutput("reset dn_valid", 32'(a_valid), 32'h0);
      checkOutput("reset adr", a_adr, RESET_PC);
      a_log.delete(); a_pend.delete(); a_acc.delete();
      b_pend.delete(); b_exp.delete();
      a_err_addr = 32'hFFFF_FFFF;
      model_pc = RESET_PC; halted = 1'b0;
      prev_stb = 1'b0; prev_pending = 1'b0; prev_flush = 1'b0;
   endtask

   // One cycle on the default instance; the bench bus answers each request one cycle after acceptance.
   task automatic applyStimulus(input logic ready, input logic flush, input logic [31:0] pc_new,
                                input logic stall, input logic hold);
      logic [31:0] a;
      @(negedge clk);
      rst = 1'b0;
      a_ready = ready; a_flush = flush; a_pc_new = pc_new; a_stall = stall;
      a_ack = 1'b0; a_err = 1'b0; a_dat_r = 32'h0;
      if (!hold && a_pend.size() > 0) begin
         a = a_pend.pop_front();
         if (a == a_err_addr) begin
            a_err = 1'b1;
         end else begin
            a_ack = 1'b1;
            a_dat_r = data_of(a);
         end
      end
      #1;
      if (a_valid && a_ready) a_log.push_back(item_t'{a_instr, a_pc, a_fault});
      if (a_stb && !a_stall) begin
         a_pend.push_back(a_adr);
         a_acc.push_back(a_adr);
      end
   endtask

   task automatic runRandomCycle();
      pend_t       p;
      logic        e;
      logic        halt_set;
      logic [31:0] d;
      int          pend_before;
      @(negedge clk);
      rst = 1'b0;
      cyc_n++;
      halt_set = 1'b0;
      b_stall  = ($urandom_range(0, 2) == 0);
      b_ready  = ($urandom_range(0, 3) != 0);
      b_flush  = ($urandom_range(0, 29) == 0);
      b_pc_new = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : 32'h0001_0000 + ($urandom_range(0, 1023) << 2);
      b_ack = 1'b0; b_err = 1'b0; b_dat_r = 32'h0;
      pend_before = b_pend.size();
      if (b_pend.size() > 0 && b_pend[0].due <= cyc_n) begin
         p = b_pend.pop_front();
         e = ($urandom_range(0, 24) == 0);
         d = $urandom;
         b_ack = ~e; b_err = e; b_dat_r = d;
         if (!p.stale && !b_flush) begin
            b_exp.push_back(item_t'{e ? 32'h0 : d, p.addr, e});
            if (e) halt_set = 1'b1;
         end
      end
      #1;
      if (prev_flush) checkOutput("stb after flush", 32'(b_stb), 32'h0);
      else if (prev_pending) checkOutput("stb held", 32'(b_stb), 32'h1);
      if (b_stb && !prev_stb && !prev_flush) checkOutput("stb rise while halted", 32'(halted), 32'h0);
      checkOutput("cyc", 32'(b_cyc), 32'(b_stb || pend_before != 0));
      checkOutput("dn_valid", 32'(b_valid), 32'(!b_flush && b_exp.size() != 0));
      if (b_valid && b_exp.size() != 0) begin
         checkOutput("dn_instr", b_instr, b_exp[0].instr);
         checkOutput("dn_pc", b_pc, b_exp[0].pc);
         checkOutput("dn_fault", 32'(b_fault), 32'(b_exp[0].fault));
         if (b_ready) void'(b_exp.pop_front());
      end
      if (b_stb && !b_stall) begin
         checkOutput("fetch adr", b_adr, model_pc);
         b_pend.push_back('{model_pc, b_flush, cyc_n + 1 + int'($urandom_range(0, 5))});
         model_pc = model_pc + 32'd4;
      end
      checkOutput("outstanding limit", 32'(b_pend.size() <= 2), 32'h1);
      if (b_flush) begin
         foreach (b_pend[i]) b_pend[i].stale = 1'b1;
         b_exp.delete();
         model_pc = b_pc_new;
         halted = 1'b0;
      end else if (halt_set) begin
         halted = 1'b1;
      end
      checkOutput("queue occupancy", 32'(b_exp.size() <= 4), 32'h1);
      prev_stb     = b_stb;
      prev_pending = b_stb && b_stall;
      prev_flush   = b_flush;
   endtask

   initial begin
      int stale_cnt;
      vecs[0] = '{1'b1, 1'b0, 1'b0, RESET_PC,         1'b0, 32'h0};
      vecs[1] = '{1'b1, 1'b0, 1'b1, RESET_PC,         1'b0, 32'h0};
      vecs[2] = '{1'b1, 1'b0, 1'b1, RESET_PC + 32'h4, 1'b1, RESET_PC};
      vecs[3] = '{1'b1, 1'b1, 1'b1, RESET_PC + 32'h8, 1'b1, RESET_PC + 32'h4};
      vecs[4] = '{1'b1, 1'b0, 1'b1, RESET_PC + 32'h8, 1'b0, 32'h0};
      vecs[5] = '{1'b0, 1'b0, 1'b1, RESET_PC + 32'hC, 1'b1, RESET_PC + 32'h8};
      vecs[6] = '{1'b0, 1'b0, 1'b1, RESET_PC + 32'h10, 1'b1, RESET_PC + 32'h8};
      vecs[7] = '{1'b1, 1'b0, 1'b1, RESET_PC + 32'h14, 1'b1, RESET_PC + 32'h8};
      vecs[8] = '{1'b1, 1'b0, 1'b1, RESET_PC + 32'h18, 1'b1, RESET_PC + 32'hC};
      cyc_n = 0;

      $display("[TB] sequential fetch vectors");
      doReset();
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].ready, 1'b0, 32'h0, vecs[i].stall, 1'b0);
         checkOutput($sformatf("vec%0d stb", i), 32'(a_stb), 32'(vecs[i].exp_stb));
         checkOutput($sformatf("vec%0d adr", i), a_adr, vecs[i].exp_adr);
         checkOutput($sformatf("vec%0d dn_valid", i), 32'(a_valid), 32'(vecs[i].exp_valid));
         if (vecs[i].exp_valid) begin
            checkOutput($sformatf("vec%0d dn_pc", i), a_pc, vecs[i].exp_pc);
            checkOutput($sformatf("vec%0d dn_instr", i), a_instr, data_of(vecs[i].exp_pc));
            checkOutput($sformatf("vec%0d dn_fault", i), 32'(a_fault), 32'h0);
         end
      end

      $display("[TB] backpressure fills the queue");
      doReset();
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("accepts under backpressure", 32'(a_acc.size()), 32'd8);
      checkOutput("stb low when full", 32'(a_stb), 32'h0);
      for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         checkOutput($sformatf("drain%0d pc", i), log_at(i).pc, RESET_PC + 32'(4 * i));
         checkOutput($sformatf("drain%0d instr", i), log_at(i).instr, data_of(RESET_PC + 32'(4 * i)));
      end
      checkOutput("fetch resumes", 32'(a_acc.size() > 8), 32'h1);

      $display("[TB] flush with three outstanding");
      doReset();
      for (int i = 0; i < 10 && a_acc.size() < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("three outstanding", 32'(a_acc.size()), 32'd3);
      applyStimulus(1'b1, 1'b1, 32'h8000_0100, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("stb low after flush", 32'(a_stb), 32'h0);
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("adr after flush", acc_at(3), 32'h8000_0100);
      checkOutput("first pc after flush", log_at(0).pc, 32'h8000_0100);
      checkOutput("first instr after flush", log_at(0).instr, data_of(32'h8000_0100));

      $display("[TB] flush while a request is accepted");
      doReset();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'h8000_0200, 1'b0, 1'b0);
      checkOutput("accept in flush cycle", 32'(a_acc.size()), 32'd1);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("stb low after flush accept", 32'(a_stb), 32'h0);
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("pc after flush accept", log_at(0).pc, 32'h8000_0200);
      stale_cnt = 0;
      foreach (a_log[i]) if (a_log[i].pc == RESET_PC) stale_cnt++;
      checkOutput("stale deliveries", 32'(stale_cnt), 32'h0);

      $display("[TB] bus error halts fetch");
      doReset();
      a_err_addr = RESET_PC + 32'h8;
      for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("accepts before halt", 32'(a_acc.size()), 32'd4);
      checkOutput("stb low while halted", 32'(a_stb), 32'h0);
      checkOutput("deliveries before halt", 32'(a_log.size()), 32'd4);
      checkOutput("fault entry flag", 32'(log_at(2).fault), 32'h1);
      checkOutput("fault entry pc", log_at(2).pc, RESET_PC + 32'h8);
      checkOutput("fault entry instr", log_at(2).instr, 32'h0);
      checkOutput("post-fault entry pc", log_at(3).pc, RESET_PC + 32'hC);
      checkOutput("post-fault entry flag", 32'(log_at(3).fault), 32'h0);
      applyStimulus(1'b1, 1'b1, 32'h8000_0300, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("adr after halt flush", acc_at(4), 32'h8000_0300);
      checkOutput("pc after halt flush", log_at(4).pc, 32'h8000_0300);
      checkOutput("fault after halt flush", 32'(log_at(4).fault), 32'h0);

      $display("[TB] randomized traffic on small instance");
      doReset();
      for (int i = 0; i < 3000; i++) runRandomCycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/prefetch_unit.md
PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000: first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: response queue entries; power of two, >= 4.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4: maximum accepted-but-unanswered bus requests; 1..FIFO_DEPTH.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 pc_flush  input  1  redirect request, single-cycle pulse.
REQ-007 pc_new  input  32  redirect target, sampled when pc_flush=1.
REQ-008 bus  wishbone.master  -  pipelined read master: cyc, stb, adr[31:0], we, sel[3:0], dat_w[31:0] out; stall, ack, err, dat_r[31:0] in.
REQ-009 dn  pipeline.dn  -  valid/ready output; data carries instr[31:0], pc[31:0], fault (1 bit).

Function
REQ-010 Constants: bus.we=0, bus.sel=4'hF, bus.dat_w=0, bus.adr=fetch pc register.
REQ-011 Request accepted when bus.stb=1 and bus.stall=0; accepted request increments fetch pc by 4 (32-bit wrap).
REQ-012 outstanding counter: +1 per accepted request, -1 per ack or err, both in one cycle -> unchanged.
REQ-013 bus.stb registered: next stb = (queue_count + outstanding_next < FIFO_DEPTH) and (outstanding_next < MAX_OUTSTANDING) and !halt and discard_next==0 and !pc_flush.
REQ-014 bus.stb, once high, SHALL stay high until accepted, except in the cycle after pc_flush (forced low).
REQ-015 bus.cyc = bus.stb or outstanding != 0.
REQ-016 pc_flush cycle: fetch pc <= pc_new (overrides +4); resp_pc <= pc_new; queue emptied; halt cleared; discard <= outstanding_next (counts request accepted in flush cycle, minus response arriving in flush cycle).
REQ-017 While discard > 0, each ack/err decrements discard and is dropped (no queue push, no dn.valid, no halt).
REQ-018 resp_pc: tracks pc of next kept response; +4 per kept response; reset to RESET_PC.
REQ-019 Kept ack: entry {instr=dat_r, pc=resp_pc, fault=0}; kept err: entry {instr=0, pc=resp_pc, fault=1} and halt <= 1.
REQ-020 halt=1: no new requests until pc_flush; already outstanding responses still processed.
REQ-021 Queue empty bypass: kept response drives dn.valid=1 and dn.data same cycle (zero latency); pushed only if dn.ready=0.
REQ-022 Queue non-empty: dn.valid=1, dn.data=head; kept response pushed at tail; head popped on dn.ready; push and pop same cycle allowed.
REQ-023 dn.valid SHALL be 0 in the pc_flush cycle regardless of queue or bus response.
REQ-024 Queue never overflows: REQ-013 guarantees capacity for every outstanding response; overflow is a design error (assertion).
REQ-025 Responses in order; no reordering, no duplication.

Reset
REQ-026 On rst: bus.stb=0, bus.cyc=0, fetch pc=resp_pc=RESET_PC, outstanding=0, discard=0, halt=0, queue empty, dn.valid=0.
REQ-027 rst mid-transaction: all outstanding state cleared; responses arriving after rst deassertion SHALL be ignored only if bench guarantees bus is also reset (bus reset assumed in same domain).
REQ-028 Queue storage not reset; only pointers.

Verification
REQ-029 Reset release, stall=0, ack 1 cycle after accept, dn.ready=1 -> adr 8000_0000, 8000_0004, ... ; dn.pc matches, dn.valid same cycle as ack.
REQ-030 dn.ready=0 for 20 cycles, zero-latency bus -> stb drops once queue_count+outstanding reaches 8; no response lost; order preserved on ready release.
REQ-031 3 outstanding, pc_flush with pc_new=8000_0100 -> next 3 acks dropped, next adr 8000_0100, first dn.pc=8000_0100.
REQ-032 pc_flush with stb=1, stall=0 same cycle -> that request counted in discard; stb low next cycle; no stale instr delivered.
REQ-033 err on request for 8000_0008 -> dn entry fault=1, pc=8000_0008; no further stb until pc_flush; flush resumes fetch at pc_new.
REQ-034 Random stall/ack latency (0-5 cycles), random dn.ready, random flushes, MAX_OUTSTANDING=2 and FIFO_DEPTH=4 -> outstanding never >2, queue never overflows, dn stream equals reference model.
